dispatch_sink: RTL and testbench

//  Output end of the dispatch protocol: receives per-cycle output fire vectors from the network
//  and encodes them into a compact packet stream back to the host.

---
 rtl/dispatch_sink_pkg.sv | 22 ++
 rtl/dispatch_sink_priority_encoder.sv | 25 ++
 rtl/dispatch_sink.sv | 151 +++++++++++++++
 tb/tb_dispatch_sink.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dispatch_sink_pkg.sv
// Shared configuration for the dispatch sink: network size, opcodes and
// packet field widths.
package dispatch_sink_pkg;

  localparam int unsigned NET_NUM_OUT = 4;
  localparam int unsigned NUM_OPS     = 3;
  localparam int unsigned OPC_WIDTH   = $clog2(NUM_OPS);
  // A single-output network still carries a 1-bit (always zero) SPK index.
  localparam int unsigned IDX_WIDTH   = (NET_NUM_OUT > 1) ? $clog2(NET_NUM_OUT) : 1;

  typedef enum logic [OPC_WIDTH-1:0] {
    OPC_NOP,
    OPC_RUN,
    OPC_SPK
  } opcode_t;

  // Payload field width: wide enough for either a RUN count or an SPK index.
  function automatic int unsigned pay_width(input int unsigned run_w);
    return (run_w > IDX_WIDTH) ? run_w : IDX_WIDTH;
  endfunction

endpackage

// File: rtl/dispatch_sink_priority_encoder.sv
// Lowest-set-bit encoder for the pending fire vector.
//  vec    in   N    pending fire flags
//  idx_c  out  IW   index of the lowest set bit (0 when vec is empty)
//  any_c  out  1    at least one bit of vec is set
module sink_priority_encoder
  import dispatch_sink_pkg::*;
#(
  parameter int unsigned N  = NET_NUM_OUT,
  parameter int unsigned IW = IDX_WIDTH
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_c = '0;
    any_c = |vec;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/dispatch_sink.sv
// Output end of the dispatch protocol. Turns per-cycle network fire vectors
// into a packet stream: SPK(idx) for each fired output (ascending), RUN(n)
// for n elapsed network cycles, emitted before the next spiking cycle, on
// saturation, or on flush.
//  clk        in   1            clock
//  arstn      in   1            asynchronous active-low reset
//  net_valid  in   1            network cycle complete, net_out valid
//  net_ready  out  1            sink accepts net_out this clock
//  net_out    in   NET_NUM_OUT  per-output fire flags
//  flush      in   1            level request to emit a pending RUN count
//  snk_valid  out  1            packet valid
//  snk_ready  in   1            downstream accepts packet
//  snk        out  OPC+PAY      {opcode, MSB-aligned payload}
module dispatch_sink
  import dispatch_sink_pkg::*;
#(
  parameter int unsigned RUN_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      arstn,
  input  logic                                      net_valid,
  output logic                                      net_ready,
  input  logic [NET_NUM_OUT-1:0]                    net_out,
  input  logic                                      flush,
  output logic                                      snk_valid,
  input  logic                                      snk_ready,
  output logic [OPC_WIDTH+pay_width(RUN_WIDTH)-1:0] snk
);

  localparam int unsigned PAY_WIDTH = pay_width(RUN_WIDTH);
  localparam int unsigned SNK_WIDTH = OPC_WIDTH + PAY_WIDTH;
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = '1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FLUSH_RUN = 2'd1;
  localparam logic [1:0] SCAN      = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [RUN_WIDTH-1:0]   run_acc_q, run_acc_d;
  logic [NET_NUM_OUT-1:0] fire_vec_q, fire_vec_d;
  logic [SNK_WIDTH-1:0]   snk_q, snk_d;
  logic                   snk_valid_q, snk_valid_d;
  logic                   rdy_en_q;

  logic [IDX_WIDTH-1:0]   spk_idx;
  logic                   fire_any;
  logic [NET_NUM_OUT-1:0] fire_clr;
  logic [PAY_WIDTH-1:0]   run_pay;
  logic [PAY_WIDTH-1:0]   spk_pay;
  logic [RUN_WIDTH-1:0]   run_inc;
  logic                   out_free;
  logic                   accept;

  sink_priority_encoder #(
    .N  (NET_NUM_OUT),
    .IW (IDX_WIDTH)
  ) u_pe (
    .vec   (fire_vec_q),
    .idx_c (spk_idx),
    .any_c (fire_any)
  );

  // Payloads are MSB-aligned within the shared payload field.
  assign run_pay  = PAY_WIDTH'(run_acc_q) << (PAY_WIDTH - RUN_WIDTH);
  assign spk_pay  = PAY_WIDTH'(spk_idx) << (PAY_WIDTH - IDX_WIDTH);
  assign fire_clr = fire_vec_q & ~(NET_NUM_OUT'(1) << spk_idx);
  assign run_inc  = run_acc_q + RUN_WIDTH'(1);

  assign out_free  = !snk_valid_q || snk_ready;
  // Hold off new cycles while a flush is owed or the counter is saturated.
  assign net_ready = rdy_en_q && (state_q == IDLE) && !(flush && (run_acc_q != '0)) &&
                     (run_acc_q != RUN_MAX);
  assign accept    = net_valid && net_ready;

  assign snk       = snk_q;
  assign snk_valid = snk_valid_q;

  // Next-state and packet generation.
  always_comb begin
    state_d     = state_q;
    run_acc_d   = run_acc_q;
    fire_vec_d  = fire_vec_q;
    snk_d       = snk_q;
    snk_valid_d = snk_valid_q;

    if (out_free) snk_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (net_out != '0) begin
            fire_vec_d = net_out;
            state_d    = (run_acc_q != '0) ? FLUSH_RUN : SCAN;
          end else begin
            run_acc_d = run_inc;
            if (run_inc == RUN_MAX) begin
              fire_vec_d = '0;
              state_d    = FLUSH_RUN;
            end
          end
        end else if (flush && (run_acc_q != '0)) begin
          fire_vec_d = '0;
          state_d    = FLUSH_RUN;
        end
      end
      FLUSH_RUN: begin
        if (out_free) begin
          snk_d       = {OPC_RUN, run_pay};
          snk_valid_d = 1'b1;
          run_acc_d   = '0;
          state_d     = (fire_vec_q != '0) ? SCAN : IDLE;
        end
      end
      SCAN: begin
        if (!fire_any) begin
          state_d = IDLE;
        end else if (out_free) begin
          snk_d       = {OPC_SPK, spk_pay};
          snk_valid_d = 1'b1;
          fire_vec_d  = fire_clr;
          // Last spike of the cycle: that network cycle has now elapsed.
          if (fire_clr == '0) begin
            run_acc_d = RUN_WIDTH'(1);
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      run_acc_q   <= '0;
      fire_vec_q  <= '0;
      snk_q       <= '0;
      snk_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_acc_q   <= run_acc_d;
      fire_vec_q  <= fire_vec_d;
      snk_q       <= snk_d;
      snk_valid_q <= snk_valid_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_sink.sv
module tb_dispatch_sink;
  import dispatch_sink_pkg::*;

  typedef struct packed {
    logic        nv;
    logic [3:0]  no;
    logic        fl;
    logic        rdy;
    logic        enr;
    logic        esv;
    logic [17:0] esnk;
  } vec_t;

  logic        clk;
  logic        arstn;

  logic        a_nv, a_nr, a_fl, a_sv, a_rdy;
  logic [3:0]  a_no;
  logic [17:0] a_snk;

  logic        b_nv, b_nr, b_fl, b_sv, b_rdy;
  logic [3:0]  b_no;
  logic [5:0]  b_snk;

  int n_tests;
  int n_fail;
  vec_t tbl[$];

  dispatch_sink u_dut (
    .clk(clk), .arstn(arstn), .net_valid(a_nv), .net_ready(a_nr), .net_out(a_no),
    .flush(a_fl), .snk_valid(a_sv), .snk_ready(a_rdy), .snk(a_snk)
  );

  dispatch_sink #(.RUN_WIDTH(4)) u_dut4 (
    .clk(clk), .arstn(arstn), .net_valid(b_nv), .net_ready(b_nr), .net_out(b_no),
    .flush(b_fl), .snk_valid(b_sv), .snk_ready(b_rdy), .snk(b_snk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive A, check A outputs, advance one clock.
  task automatic step_a(input string nm, input logic nv, input logic [3:0] no, input logic fl,
                        input logic rdy, input logic enr, input logic esv, input logic [17:0] esnk);
    a_nv = nv; a_no = no; a_fl = fl; a_rdy = rdy;
    #1;
    chk({nm, " net_ready"}, 32'(a_nr), 32'(enr));
    chk({nm, " snk_valid"}, 32'(a_sv), 32'(esv));
    if (esv) chk({nm, " snk"}, 32'(a_snk), 32'(esnk));
    @(negedge clk);
  endtask

  task automatic step_b(input string nm, input logic nv, input logic [3:0] no,
                        input logic enr, input logic esv, input logic [5:0] esnk);
    b_nv = nv; b_no = no;
    #1;
    chk({nm, " net_ready"}, 32'(b_nr), 32'(enr));
    chk({nm, " snk_valid"}, 32'(b_sv), 32'(esv));
    if (esv) chk({nm, " snk"}, 32'(b_snk), 32'(esnk));
    @(negedge clk);
  endtask

  task automatic add(input logic nv, input logic [3:0] no, input logic fl, input logic rdy,
                     input logic enr, input logic esv, input logic [17:0] esnk);
    vec_t v;
    v.nv = nv; v.no = no; v.fl = fl; v.rdy = rdy; v.enr = enr; v.esv = esv; v.esnk = esnk;
    tbl.push_back(v);
  endtask

  // Packet encodings for RUN_WIDTH=16: {opc[17:16], payload[15:0]}, index in [15:14].
  localparam logic [17:0] RUN1 = 18'h10001;
  localparam logic [17:0] RUN2 = 18'h10002;
  localparam logic [17:0] RUN3 = 18'h10003;
  localparam logic [17:0] SPK0 = 18'h20000;
  localparam logic [17:0] SPK1 = 18'h24000;
  localparam logic [17:0] SPK2 = 18'h28000;
  localparam logic [17:0] SPK3 = 18'h2C000;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    arstn = 1'b0;
    a_nv = 0; a_no = '0; a_fl = 0; a_rdy = 1;
    b_nv = 0; b_no = '0; b_fl = 0; b_rdy = 1;

    // 3 silent cycles then 0101; back-to-back 1000 / 0001.
    add(1, 4'h0, 0, 1, 1, 0, '0);
    add(1, 4'h0, 0, 1, 1, 0, '0);
    add(1, 4'h0, 0, 1, 1, 0, '0);
    add(1, 4'h5, 0, 1, 1, 0, '0);
    add(0, 4'h0, 0, 1, 0, 0, '0);
    add(0, 4'h0, 0, 1, 0, 1, RUN3);
    add(0, 4'h0, 0, 1, 0, 1, SPK0);
    add(1, 4'h8, 0, 1, 1, 1, SPK2);
    add(0, 4'h0, 0, 1, 0, 0, '0);
    add(1, 4'h1, 0, 1, 0, 1, RUN1);
    add(1, 4'h1, 0, 1, 1, 1, SPK3);
    add(0, 4'h0, 0, 1, 0, 0, '0);
    add(0, 4'h0, 0, 1, 0, 1, RUN1);
    add(0, 4'h0, 0, 1, 1, 1, SPK0);
    add(0, 4'h0, 0, 1, 1, 0, '0);
    // flush with run_acc=2 while net_valid is high.
    add(1, 4'h0, 0, 1, 1, 0, '0);
    add(1, 4'h0, 1, 1, 0, 0, '0);
    add(1, 4'h0, 1, 1, 0, 0, '0);
    add(1, 4'h2, 1, 1, 1, 1, RUN2);
    add(0, 4'h0, 0, 1, 0, 0, '0);
    add(0, 4'h0, 0, 1, 1, 1, SPK1);
    add(0, 4'h0, 0, 1, 1, 0, '0);
    // snk_ready low for 5 clocks mid-scan.
    add(1, 4'hE, 0, 1, 1, 0, '0);
    add(0, 4'h0, 0, 1, 0, 0, '0);
    add(0, 4'h0, 0, 1, 0, 1, RUN1);
    add(0, 4'h0, 0, 0, 0, 1, SPK1);
    for (int i = 0; i < 4; i++) add(1, 4'h1, 0, 0, 0, 1, SPK1);
    add(0, 4'h0, 0, 1, 0, 1, SPK1);
    add(0, 4'h0, 0, 1, 0, 1, SPK2);
    add(0, 4'h0, 0, 1, 1, 1, SPK3);
    add(0, 4'h0, 0, 1, 1, 0, '0);

    // Reset state.
    #2;
    chk("reset net_ready", 32'(a_nr), 32'd0);
    chk("reset snk_valid", 32'(a_sv), 32'd0);
    chk("reset snk", 32'(a_snk), 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      step_a($sformatf("vec%0d", i), tbl[i].nv, tbl[i].no, tbl[i].fl, tbl[i].rdy,
             tbl[i].enr, tbl[i].esv, tbl[i].esnk);
    end

    // Reset during SCAN with three spikes pending.
    step_a("rst pre0", 1, 4'h7, 0, 1, 1, 0, '0);
    step_a("rst pre1", 0, 4'h0, 0, 1, 0, 0, '0);
    arstn = 1'b0;
    #1;
    chk("rst snk_valid", 32'(a_sv), 32'd0);
    chk("rst snk", 32'(a_snk), 32'd0);
    chk("rst net_ready", 32'(a_nr), 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    step_a("post0", 1, 4'h0, 0, 1, 1, 0, '0);
    step_a("post1", 1, 4'h1, 0, 1, 1, 0, '0);
    step_a("post2", 0, 4'h0, 0, 1, 0, 0, '0);
    step_a("post3", 0, 4'h0, 0, 1, 0, 1, RUN1);
    step_a("post4", 0, 4'h0, 0, 1, 1, 1, SPK0);
    step_a("post5", 0, 4'h0, 0, 1, 1, 0, '0);

    // RUN_WIDTH=4 saturation: 15 silent cycles force RUN(15).
    for (int i = 0; i < 15; i++) step_b($sformatf("sat%0d", i), 1, 4'h0, 1, 0, '0);
    step_b("sat hold", 1, 4'h0, 0, 0, '0);
    step_b("sat run", 0, 4'h0, 1, 1, 6'h1F);
    step_b("sat spk0", 1, 4'h4, 1, 0, '0);
    step_b("sat spk1", 0, 4'h0, 0, 0, '0);
    step_b("sat spk2", 0, 4'h0, 1, 1, 6'h28);
    step_b("sat spk3", 0, 4'h0, 1, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
